// File: rtl/csa42_pipe_acc.sv
// Pipelined 4:2 carry-save compressor / redundant accumulator; result stays as (Ws, Wc).
// Define CSA_CARRY_OUT_EN to add the 2-bit cout port carrying the discarded MSB majority bits.
module csa42_pipe_acc #(
    parameter int WL  = 8,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          en,
    input  logic          in_valid,
    input  logic          acc,
    input  logic          clr,
    input  logic [WL-1:0] a,
    input  logic [WL-1:0] b,
    input  logic [WL-1:0] c,
    input  logic [WL-1:0] d,
    input  logic          cin1,
    input  logic          cin2,
    output logic          out_valid,
    output logic [WL-1:0] Ws,
    output logic [WL-1:0] Wc
`ifdef CSA_CARRY_OUT_EN
    ,
    output logic [1:0]    cout
`endif
);

    logic [WL-1:0] s_q [LAT];
    logic [WL-1:0] s_d [LAT];
    logic [WL-1:0] c_q [LAT];
    logic [WL-1:0] c_d [LAT];
    logic [LAT-1:0] v_q, v_d;

    logic [WL-1:0] r_op, t_op, s1, c1, ws_n, wc_n;
    logic [WL-2:0] maj1_lo, maj2_lo;

    // Accumulate beats feed the held stage-1 state back in as the third and fourth operand.
    always_comb begin
        r_op = c;
        t_op = d;
        if (acc) begin
            r_op = clr ? '0 : s_q[0];
            t_op = clr ? '0 : c_q[0];
        end
        s1      = a ^ b ^ r_op;
        maj1_lo = (a[WL-2:0] & b[WL-2:0]) | (a[WL-2:0] & r_op[WL-2:0]) | (b[WL-2:0] & r_op[WL-2:0]);
        c1      = {maj1_lo, cin1};
        ws_n    = s1 ^ c1 ^ t_op;
        maj2_lo = (s1[WL-2:0] & c1[WL-2:0]) | (s1[WL-2:0] & t_op[WL-2:0]) | (c1[WL-2:0] & t_op[WL-2:0]);
        wc_n    = {maj2_lo, cin2};
    end

    always_comb begin
        s_d = s_q;
        c_d = c_q;
        v_d = v_q;
        if (en) begin
            for (int k = LAT - 1; k > 0; k--) begin
                s_d[k] = s_q[k-1];
                c_d[k] = c_q[k-1];
                v_d[k] = v_q[k-1];
            end
            v_d[0] = in_valid;
            if (in_valid) begin
                s_d[0] = ws_n;
                c_d[0] = wc_n;
            end else if (clr) begin
                s_d[0] = '0;
                c_d[0] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < LAT; k++) begin
                s_q[k] <= '0;
                c_q[k] <= '0;
            end
            v_q <= '0;
        end else begin
            for (int k = 0; k < LAT; k++) begin
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            v_q <= v_d;
        end
    end

    assign Ws        = s_q[LAT-1];
    assign Wc        = c_q[LAT-1];
    assign out_valid = v_q[LAT-1];

`ifdef CSA_CARRY_OUT_EN
    logic [1:0] co_n;
    logic [1:0] co_q [LAT];
    logic [1:0] co_d [LAT];

    // Discarded MSB majorities travel with their data so cascades see them aligned.
    always_comb begin
        co_n[0] = (a[WL-1] & b[WL-1]) | (a[WL-1] & r_op[WL-1]) | (b[WL-1] & r_op[WL-1]);
        co_n[1] = (s1[WL-1] & c1[WL-1]) | (s1[WL-1] & t_op[WL-1]) | (c1[WL-1] & t_op[WL-1]);
        co_d    = co_q;
        if (en) begin
            for (int k = LAT - 1; k > 0; k--) begin
                co_d[k] = co_q[k-1];
            end
            if (in_valid) begin
                co_d[0] = co_n;
            end else if (clr) begin
                co_d[0] = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < LAT; k++) begin
                co_q[k] <= 2'b00;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                co_q[k] <= co_d[k];
            end
        end
    end

    assign cout = co_q[LAT-1];
`endif

endmodule

// File: tb/tb_csa42_pipe_acc.sv
// Directed + random bench for csa42_pipe_acc; the reference tracks only the represented
// value (Ws+Wc mod 2^WL) and validity of each pipeline slot.
module tb_csa42_pipe_acc;
    localparam int WL  = 8;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       nReset, en, in_valid, acc, clr, cin1, cin2;
    logic [7:0] a, b, c, d, Ws, Wc;
    logic       out_valid, out_valid3;
    logic [2:0] Ws3, Wc3;
`ifdef CSA_CARRY_OUT_EN
    logic [1:0] cout, cout3;
`endif

    int errors = 0;
    int checks = 0;
    int got_q[$];
    bit m_v[LAT];
    int m_s[LAT];

    always #5 clk = ~clk;

    csa42_pipe_acc #(.WL(WL), .LAT(LAT)) dut (
        .clk(clk), .nReset(nReset), .en(en), .in_valid(in_valid), .acc(acc), .clr(clr),
        .a(a), .b(b), .c(c), .d(d), .cin1(cin1), .cin2(cin2),
        .out_valid(out_valid), .Ws(Ws), .Wc(Wc)
`ifdef CSA_CARRY_OUT_EN
        , .cout(cout)
`endif
    );

    csa42_pipe_acc #(.WL(3), .LAT(2)) dut3 (
        .clk(clk), .nReset(nReset), .en(en), .in_valid(in_valid), .acc(acc), .clr(clr),
        .a(a[2:0]), .b(b[2:0]), .c(c[2:0]), .d(d[2:0]), .cin1(cin1), .cin2(cin2),
        .out_valid(out_valid3), .Ws(Ws3), .Wc(Wc3)
`ifdef CSA_CARRY_OUT_EN
        , .cout(cout3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < LAT; k++) begin
            m_v[k] = 1'b0;
            m_s[k] = 0;
        end
    endtask

    // One clock: drive, let the consumer take the current output, advance the model, compare.
    task automatic step(input bit e, input bit vin, input bit ac, input bit cl,
                        input int ai, input int bi, input int ci, input int di,
                        input bit c1i, input bit c2i);
        logic [7:0] s8;
        int base;
        en = e; in_valid = vin; acc = ac; clr = cl;
        a = ai[7:0]; b = bi[7:0]; c = ci[7:0]; d = di[7:0];
        cin1 = c1i; cin2 = c2i;
        s8 = Ws + Wc;
        if (out_valid === 1'b1 && e) got_q.push_back(int'(s8));
        @(posedge clk);
        if (e) begin
            for (int k = LAT - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1];
                m_s[k] = m_s[k-1];
            end
            if (vin) begin
                base   = ac ? (cl ? 0 : m_s[0]) : ci + di;
                m_s[0] = (ai + bi + base + int'(c1i) + int'(c2i)) % 256;
                m_v[0] = 1'b1;
            end else begin
                if (cl) m_s[0] = 0;
                m_v[0] = 1'b0;
            end
        end
        #1;
        s8 = Ws + Wc;
        chk("out_valid", 32'(out_valid), 32'(m_v[LAT-1]));
        chk("sum", 32'(s8), 32'(m_s[LAT-1]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_seq(input string tag, input int n, input int e0, input int e1,
                             input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) chk(tag, 32'(got_q[i]), 32'(e[i]));
        end
        $display("seq %s: %0d beats observed", tag, got_q.size());
        got_q.delete();
    endtask

    initial begin
        logic [7:0] s8;
        nReset = 1'b0; en = 1'b1; in_valid = 1'b0; acc = 1'b0; clr = 1'b0;
        a = '0; b = '0; c = '0; d = '0; cin1 = 1'b0; cin2 = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Ws", 32'(Ws), 32'd0);
        chk("rst_Wc", 32'(Wc), 32'd0);
        chk("rst_out_valid3", 32'(out_valid3), 32'd0);
        nReset = 1'b1;

        // WL=3 directed case: sum 7 in redundant form 000 / 111
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 6, 6, 1'b1, 1'b1);
        chk("w3_valid_early", 32'(out_valid3), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("w3_valid", 32'(out_valid3), 32'd1);
        chk("w3_Ws", 32'(Ws3), 32'd0);
        chk("w3_Wc", 32'(Wc3), 32'd7);
`ifdef CSA_CARRY_OUT_EN
        chk("w3_cout", 32'(cout3), 32'd2);
`endif
        $display("txn w3: Ws=%0d Wc=%0d", Ws3, Wc3);
        idle(2);
        got_q.delete();

        // Accumulate run; c/d carry junk that must be ignored
        step(1'b1, 1'b1, 1'b1, 1'b1, 10, 20, 170, 85, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1, 2, 170, 85, 1'b0, 1'b0);
        idle(3);
        check_seq("acc_run", 4, 30, 33, 36, 39);

        // Same run with a two-cycle bubble between beats 2 and 3
        step(1'b1, 1'b1, 1'b1, 1'b1, 10, 20, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1, 2, 0, 0, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1, 2, 0, 0, 1'b0, 1'b0);
        idle(3);
        check_seq("acc_bubble", 4, 30, 33, 36, 39);

        // Stall with two beats in flight; inputs during the stall must be ignored
        step(1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 3, 4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 7, 8, 9, 10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 99, 99, 99, 99, 1'b1, 1'b1);
        idle(3);
        check_seq("stall", 2, 10, 34, 0, 0);

        // All-ones wraparound
        step(1'b1, 1'b1, 1'b0, 1'b0, 255, 255, 255, 255, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        s8 = Ws + Wc;
        chk("ones_sum", 32'(s8), 32'd254);
`ifdef CSA_CARRY_OUT_EN
        chk("ones_cout", 32'(cout), 32'd3);
`endif
        idle(2);
        got_q.delete();

        // Asynchronous reset between edges, mid-accumulation
        step(1'b1, 1'b1, 1'b1, 1'b1, 50, 60, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3, 4, 0, 0, 1'b0, 1'b0);
        #2 nReset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_Ws", 32'(Ws), 32'd0);
        chk("arst_Wc", 32'(Wc), 32'd0);
        #1 nReset = 1'b1;
        model_reset();
        got_q.delete();
        step(1'b1, 1'b1, 1'b1, 1'b0, 5, 0, 0, 0, 1'b0, 1'b0);
        idle(3);
        check_seq("post_reset", 1, 5, 0, 0, 0);

        // Random mixed-mode traffic with stalls, bubbles and clears
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
